// File: rtl/fft_bin_seq.sv
// fft_bin_seq -- tags every valid power-spectrum sample with its FFT bin
// index, channel, start/end-of-frame flags and a frame number, for
// time-interleaved multi-channel streams.
//
// Optional feature macro: BIN_SEQ_SYNC_CHECK_EN
//   defined   : in_last forces end-of-frame and resyncs the channel counter;
//               disagreement between in_last and the local count sets the
//               sticky sync_err.
//   undefined : in_last ignored, sync_err tied to 0.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (also captures cfg_full_spec)
//   sclr           synchronous soft clear, same effect as rst
//   cfg_full_spec  0: N_FFT/2+1 bins per frame, 1: N_FFT bins per frame
//   in_valid/in_ch/in_last   sample strobe, channel tag, upstream frame end
//   out_valid/out_bin/out_ch/out_sof/out_eof   tags, one cycle after input
//   frame_cnt      completed frames of channel NUM_CH-1
//   sync_err       sticky frame-sync error

// Per-channel bin counter.
module fft_bin_lane #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         hit,
    input  logic         wrap,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (hit)
            cnt <= wrap ? '0 : W'(cnt + 1'b1);
    end
endmodule

module fft_bin_seq #(
    parameter int N_FFT         = 512,
    parameter int NUM_CH        = 1,
    parameter int FRAME_W       = 16,
    parameter int FFT_IDX_WIDTH = $clog2(N_FFT),
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclr,
    input  logic                     cfg_full_spec,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic [FFT_IDX_WIDTH-1:0] out_bin,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic [FRAME_W-1:0]       frame_cnt,
    output logic                     sync_err
);
    localparam int STAGES = 1;
    localparam logic [FFT_IDX_WIDTH-1:0] LAST_FULL = FFT_IDX_WIDTH'(N_FFT - 1);
    localparam logic [FFT_IDX_WIDTH-1:0] LAST_HALF = FFT_IDX_WIDTH'(N_FFT / 2);

    typedef struct packed {
        logic [FFT_IDX_WIDTH-1:0] bin;
        logic [CH_W-1:0]          ch;
        logic                     sof;
        logic                     eof;
    } tag_t;

    logic                                  clr;
    logic                                  cfg_full_q;
    logic [FFT_IDX_WIDTH-1:0]              last_bin;
    logic                                  accept;
    logic [NUM_CH-1:0]                     hit;
    logic [NUM_CH-1:0][FFT_IDX_WIDTH-1:0]  cnt;
    logic [FFT_IDX_WIDTH-1:0]              cur_cnt;
    logic                                  at_last;
    logic                                  eof_now;
    logic [STAGES:0]                       vld_pipe;
    tag_t                                  tag_q;

    assign clr      = rst | sclr;
    assign last_bin = cfg_full_q ? LAST_FULL : LAST_HALF;
    // Out-of-range channel tags (possible when NUM_CH is not a power of two)
    // are dropped before they reach any counter.
    assign accept   = in_valid && !clr && (32'(in_ch) < 32'(NUM_CH));

    // Spectrum mode is only re-read on a clear so a frame never changes length.
    always_ff @(posedge clk) begin
        if (clr)
            cfg_full_q <= cfg_full_spec;
    end

    // Select the addressed channel's counter; only one lane is hit per cycle,
    // so the wrap decision can be made once here and shared by all lanes.
    always_comb begin
        cur_cnt = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (in_ch == CH_W'(c))
                cur_cnt = cnt[c];
    end

    assign at_last = (cur_cnt == last_bin);

`ifdef BIN_SEQ_SYNC_CHECK_EN
    // Upstream framing wins: in_last always closes the frame.
    assign eof_now = at_last | in_last;

    always_ff @(posedge clk) begin
        if (clr)
            sync_err <= 1'b0;
        else if (accept && (in_last != at_last))
            sync_err <= 1'b1;
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign eof_now        = at_last;
    assign sync_err       = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            assign hit[g] = accept && (in_ch == CH_W'(g));
            fft_bin_lane #(.W(FFT_IDX_WIDTH)) u_lane (
                .clk  (clk),
                .clr  (clr),
                .hit  (hit[g]),
                .wrap (eof_now),
                .cnt  (cnt[g])
            );
        end
    endgenerate

    assign vld_pipe[0] = accept;

    always_ff @(posedge clk) begin
        if (clr)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Tags hold their last value while no sample is presented.
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_q <= '0;
        end else if (accept) begin
            tag_q.bin <= cur_cnt;
            tag_q.ch  <= in_ch;
            tag_q.sof <= (cur_cnt == '0);
            tag_q.eof <= eof_now;
        end
    end

    // Updated on the same edge as the tags so the new count is visible
    // alongside out_eof.
    always_ff @(posedge clk) begin
        if (clr)
            frame_cnt <= '0;
        else if (accept && eof_now && (in_ch == CH_W'(NUM_CH - 1)))
            frame_cnt <= FRAME_W'(frame_cnt + 1'b1);
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_bin   = tag_q.bin;
    assign out_ch    = tag_q.ch;
    assign out_sof   = tag_q.sof;
    assign out_eof   = tag_q.eof;
endmodule

// File: tb/tb_fft_bin_seq.sv
// Self-checking bench for fft_bin_seq: randomized and directed stimulus,
// reference model computes expected tags which a monitor compares against
// every out_valid cycle.
module tb_fft_bin_seq;
    localparam int N   = 64;
    localparam int NCH = 3;
    localparam int FW  = 16;
    localparam int IW  = $clog2(N);
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst, sclr, cfg_full_spec, in_valid, in_last;
    logic [CW-1:0] in_ch;
    logic          out_valid, out_sof, out_eof, sync_err;
    logic [IW-1:0] out_bin;
    logic [CW-1:0] out_ch;
    logic [FW-1:0] frame_cnt;

    fft_bin_seq #(.N_FFT(N), .NUM_CH(NCH), .FRAME_W(FW)) dut (
        .clk(clk), .rst(rst), .sclr(sclr), .cfg_full_spec(cfg_full_spec),
        .in_valid(in_valid), .in_ch(in_ch), .in_last(in_last),
        .out_valid(out_valid), .out_bin(out_bin), .out_ch(out_ch),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int ch;
        int sof;
        int eof;
        int frame;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: position of each channel inside its frame.
    int m_pos[NCH];
    int m_full, m_frame, m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int ch, input bit last,
                         input bit s, input bit r, input bit cfg);
        exp_t e;
        int   frame_len;
        bit   closes;
        @(negedge clk);
        in_valid = v; in_ch = CW'(ch); in_last = last;
        sclr = s; rst = r; cfg_full_spec = cfg;
        if (r || s) begin
            foreach (m_pos[c]) m_pos[c] = 0;
            m_frame = 0; m_err = 0; m_full = cfg;
        end else if (v && ch < NCH) begin
            frame_len = m_full ? N : N / 2 + 1;
            closes = (m_pos[ch] == frame_len - 1);
`ifdef BIN_SEQ_SYNC_CHECK_EN
            if (last != closes) m_err = 1;
            closes = closes || last;
`endif
            e.bin = m_pos[ch];
            e.ch  = ch;
            e.sof = (m_pos[ch] == 0);
            e.eof = closes;
            m_pos[ch] = closes ? 0 : m_pos[ch] + 1;
            if (closes && ch == NCH - 1) m_frame = (m_frame + 1) % (1 << FW);
            e.frame = m_frame;
            e.err   = m_err;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, m_full[0]);
    endtask

    task automatic check_zero(input string tag);
        @(posedge clk); #1;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_bin"},   out_bin,   0);
        chk({tag, "_ch"},    out_ch,    0);
        chk({tag, "_sof"},   out_sof,   0);
        chk({tag, "_eof"},   out_eof,   0);
        chk({tag, "_frame"}, frame_cnt, 0);
        chk({tag, "_err"},   sync_err,  0);
    endtask

    // Monitor: every presented sample must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_bin",   out_bin,   e.bin);
                chk("out_ch",    out_ch,    e.ch);
                chk("out_sof",   out_sof,   e.sof);
                chk("out_eof",   out_eof,   e.eof);
                chk("frame_cnt", frame_cnt, e.frame);
                chk("sync_err",  sync_err,  e.err);
            end
        end
    end

    initial begin
        rst = 1; sclr = 0; cfg_full_spec = 0; in_valid = 0; in_ch = '0; in_last = 0;
        m_full = 0; m_frame = 0; m_err = 0;
        foreach (m_pos[c]) m_pos[c] = 0;

        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        check_zero("reset");

        // Half mode, long burst on one channel, then enough on the last
        // channel for two full frames (33 bins each).
        for (int i = 0; i < 150; i++) drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 66; i++)  drive(1, 2, 0, 0, 0, 0);
        idle(1);
        @(posedge clk); #1;
        chk("frame_cnt_two_frames", frame_cnt, 2);

        // Full mode via sclr; cfg toggles afterwards must not matter.
        drive(0, 0, 0, 1, 0, 1);
        check_zero("sclr_cfg");
        for (int i = 0; i < 130; i++) drive(1, 2, 0, 0, 0, $urandom_range(0, 1));
        idle(1);
        @(posedge clk); #1;
        chk("frame_cnt_full", frame_cnt, 2);

        // Round robin with gaps and the out-of-range tag 3 mixed in.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, i % 4, 0, 0, 0, m_full[0]);

        // sclr colliding with a valid sample mid-frame.
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0);
        check_zero("sclr_with_valid");
        drive(1, 1, 0, 0, 0, 0);

        // Early upstream end-of-frame marker at bin 5 on channel 1.
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        idle(2);

        // Random mix, including in_last, clears and mode changes.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0,
                  $urandom_range(0, 600) == 0, $urandom_range(0, 1));

        // rst mid-frame on channel 2.
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 2, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 1, 0);
        check_zero("rst_mid_frame");
        drive(1, 2, 0, 0, 0, 0);
        idle(3);

        chk("pending_expectations", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_bin_seq.md
# fft_bin_seq

Parametrised successor to the single-channel FFT bin counter. It tags every valid power-spectrum sample with its FFT bin index, channel, start/end-of-frame flags and a frame number. It supports time-interleaved multi-channel streams, a half/full spectrum mode and optional frame-sync checking. It sits between the power-spectrum stage and the mel filterbank; its outputs drive filter-coefficient lookup and accumulator dump timing.

## Interface
- `N_FFT`, 512: FFT size; must be a power of two, ≥ 4.
- `NUM_CH`, 1: number of interleaved channels, 1..16.
- `FRAME_W`, 16: frame counter width.
- `FFT_IDX_WIDTH`, `$clog2(N_FFT)`: bin index width.
- `CH_W`, `(NUM_CH>1)?$clog2(NUM_CH):1`: channel tag width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclr`  in  1  synchronous soft clear; same effect as `rst`.
- `cfg_full_spec`  in  1  0 = N_FFT/2+1 bins per frame, 1 = N_FFT bins per frame; sampled only on `rst`/`sclr`.
- `in_valid`  in  1  a power-spectrum sample is present this cycle.
- `in_ch`  in  CH_W  channel of the sample.
- `in_last`  in  1  upstream end-of-frame marker; used only with `BIN_SEQ_SYNC_CHECK_EN`.
- `out_valid`  out  1  tag outputs valid.
- `out_bin`  out  FFT_IDX_WIDTH  bin index of the tagged sample.
- `out_ch`  out  CH_W  channel of the tagged sample.
- `out_sof`  out  1  the tagged sample is bin 0.
- `out_eof`  out  1  the tagged sample is the last bin.
- `frame_cnt`  out  FRAME_W  completed frames of channel NUM_CH-1.
- `sync_err`  out  1  sticky frame-sync error.

## Operation
- `LAST` = `cfg_full_spec_q ? N_FFT-1 : N_FFT/2`. `cfg_full_spec_q` is captured on `rst` or `sclr`; on `rst` it loads the current `cfg_full_spec`.
- The block holds one bin counter per channel, `cnt[c]`, FFT_IDX_WIDTH bits each. All counters are 0 after `rst`/`sclr`.
- An accepted sample is one with `in_valid=1` and `in_ch < NUM_CH`. Samples with `in_ch ≥ NUM_CH` are dropped: no output, no counter change.
- For each accepted sample on channel c:
  - `out_bin` = `cnt[c]`; `out_sof` = (`cnt[c]`==0); `out_eof` = (`cnt[c]`==LAST).
  - `cnt[c]` is set to 0 if `cnt[c]`==LAST, otherwise incremented by 1. Wrap compares use equality, never ≥ on a truncated constant.
- `frame_cnt` increments when an accepted sample on channel NUM_CH-1 has eof. It wraps modulo 2^FRAME_W.
- Channels are independent. Any interleave order is legal, including bursts on one channel.
- `sclr` and `rst` take priority over a simultaneous `in_valid`; that sample is dropped. Both clear all counters, `frame_cnt`, `sync_err` and all outputs.
- Reset values: every output is 0.

## Timing
- One-cycle latency: a sample accepted in cycle t gives `out_valid=1` with its tags in cycle t+1.
- `out_valid` is 0 in any cycle after a non-accepted cycle. The tag outputs hold their last values when `out_valid=0`.
- `frame_cnt` updates in the same cycle that the eof sample is presented, i.e. it is visible alongside `out_eof`.
- There is no backpressure. One sample per cycle is sustained indefinitely.
- `sync_err` is set in the cycle after the detecting sample and holds until `rst` or `sclr`.

## Configuration
- `BIN_SEQ_SYNC_CHECK_EN` defined:
  - On each accepted sample, a mismatch sets `sync_err`. A mismatch is `in_last=1` with `cnt[c]`≠LAST, or `in_last=0` with `cnt[c]`==LAST.
  - `in_last=1` always forces `cnt[c]` to 0 and `out_eof=1`, so the channel resyncs to upstream framing.
  - A mismatch with `in_last=0` at LAST wraps normally.
- `BIN_SEQ_SYNC_CHECK_EN` undefined: `in_last` is ignored and `sync_err` is tied to 0. Counting follows LAST only.

## Test plan
- NUM_CH=1, N_FFT=512, half mode, 600 consecutive valids → `out_bin` runs 0..256 then 0..; `out_eof` on the 257th output; `frame_cnt`=2 after 514 samples.
- `cfg_full_spec=1` then `sclr`, 512 valids → `out_eof` at `out_bin`=511. Toggling `cfg_full_spec` without `sclr` changes nothing.
- NUM_CH=4, round-robin channels 0..3 with gaps on `in_valid` → each channel counts independently; `frame_cnt` increments only on channel 3 eof; an `in_ch`=5 (CH_W=2 can't; use NUM_CH=3, `in_ch`=3) sample is dropped.
- `sclr` asserted with `in_valid`=1 at `out_bin`=100 → next cycle `out_valid`=0, all outputs 0; the next sample is tagged bin 0, sof=1.
- With `BIN_SEQ_SYNC_CHECK_EN`, `in_last`=1 at bin 100 → `sync_err`=1, eof=1, the following sample is bin 0. Without the macro → bin 101 follows and `sync_err`=0.
- `rst` mid-frame at bin 200 on channel 2 → all outputs 0 and all counters 0; `frame_cnt`=0.
